// File: rtl/hazard_ctrl_sb.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_sb
//   Hazard controller for the 5-stage RISC-V pipeline:
//     * EX operand forwarding selects (EX/MEM has priority over MEM/WB)
//     * load-use stall for the instruction sitting in ID
//     * one-entry scoreboard for a multi-cycle MUL/DIV unit (MDU), stalling
//       readers of its destination, and any new MDU op, until writeback is done
//
//   Optional build macro: HAZARD_PERF_CNT_EN
//     defined   -> stall_cycles is a saturating count of stalled clocks
//     undefined -> no counter register, stall_cycles is tied to 0
//
//   Ports
//     clk, rst                     clock, synchronous active-high reset
//     rs1_IFID, rs2_IFID           sources of the instruction in ID
//     is_mdu_IFID                  instruction in ID is a MUL/DIV
//     rs1_IDEX, rs2_IDEX, rd_IDEX  sources/destination of the instruction in EX
//     MemRead_IDEX                 instruction in EX is a load
//     rd_EXMEM, RegWrite_EXMEM     destination/write enable of MEM stage
//     rd_MEMWB, RegWrite_MEMWB     destination/write enable of WB stage
//     mdu_start, mdu_rd            MDU issue pulse and its destination
//     ForwardA, ForwardB           00 regfile, 10 EX/MEM, 01 MEM/WB
//     pc_hold, ifid_hold,
//     idex_bubble                  stall controls (all equal)
//     mdu_busy                     scoreboard entry live (BUSY or WB)
//     mdu_wb_en, mdu_wb_rd         MDU writeback strobe and destination
//     stall_cycles                 stall performance counter
//
//   Scoreboard state is observable externally: {mdu_busy, mdu_wb_en} reads
//   00 in IDLE, 10 in BUSY and 11 in WB.
//
//   Handshake: mdu_start is a single-cycle pulse, accepted only in IDLE. The
//   structural stall (is_mdu_IFID while the entry is live) keeps a second MDU
//   op out of EX, so a pulse in BUSY/WB is a protocol violation and is ignored.
// -----------------------------------------------------------------------------
module hazard_ctrl_sb #(
   parameter int ADDR_W  = 5,
   parameter int MDU_LAT = 4,
   parameter int CNT_W   = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] rs1_IFID,
   input  logic [ADDR_W-1:0] rs2_IFID,
   input  logic              is_mdu_IFID,
   input  logic [ADDR_W-1:0] rs1_IDEX,
   input  logic [ADDR_W-1:0] rs2_IDEX,
   input  logic [ADDR_W-1:0] rd_IDEX,
   input  logic              MemRead_IDEX,
   input  logic [ADDR_W-1:0] rd_EXMEM,
   input  logic              RegWrite_EXMEM,
   input  logic [ADDR_W-1:0] rd_MEMWB,
   input  logic              RegWrite_MEMWB,
   input  logic              mdu_start,
   input  logic [ADDR_W-1:0] mdu_rd,
   output logic [1:0]        ForwardA,
   output logic [1:0]        ForwardB,
   output logic              pc_hold,
   output logic              ifid_hold,
   output logic              idex_bubble,
   output logic              mdu_busy,
   output logic              mdu_wb_en,
   output logic [ADDR_W-1:0] mdu_wb_rd,
   output logic [CNT_W-1:0]  stall_cycles
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_WB   = 2'd2
   } sb_state_t;

   localparam logic [7:0]        CNT_INIT = 8'(MDU_LAT - 1);
   localparam logic              LAT_ONE  = (MDU_LAT == 1);
   localparam logic [ADDR_W-1:0] ZERO_RD  = '0;

   sb_state_t         state, state_nxt;
   logic [ADDR_W-1:0] pend_rd, pend_rd_nxt;
   logic [7:0]        cnt, cnt_nxt;

   logic              ld_haz;
   logic              sb_haz;
   logic              stall;

   // ---------------------------------------------------------------------------
   // Forwarding
   // ---------------------------------------------------------------------------
   function automatic logic [1:0] fwd_sel(input logic [ADDR_W-1:0] src);
      logic [1:0] sel;
      sel = 2'b00;
      if (RegWrite_EXMEM && (rd_EXMEM != ZERO_RD) && (rd_EXMEM == src))
         sel = 2'b10;
      else if (RegWrite_MEMWB && (rd_MEMWB != ZERO_RD) && (rd_MEMWB == src))
         sel = 2'b01;
      return sel;
   endfunction

   always_comb begin
      ForwardA = 2'b00;
      ForwardB = 2'b00;
      if (!rst) begin
         ForwardA = fwd_sel(rs1_IDEX);
         ForwardB = fwd_sel(rs2_IDEX);
      end
   end

   // ---------------------------------------------------------------------------
   // Scoreboard FSM
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         pend_rd <= '0;
         cnt     <= '0;
      end else begin
         state   <= state_nxt;
         pend_rd <= pend_rd_nxt;
         cnt     <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      pend_rd_nxt = pend_rd;
      cnt_nxt     = cnt;
      case (state)
         S_IDLE: begin
            if (mdu_start) begin
               pend_rd_nxt = mdu_rd;
               cnt_nxt     = CNT_INIT;
               state_nxt   = LAT_ONE ? S_WB : S_BUSY;
            end
         end
         S_BUSY: begin
            // cnt holds the BUSY cycles still to go including this one,
            // so the last BUSY cycle is the one where cnt is 1.
            if (cnt <= 8'd1) begin
               cnt_nxt   = 8'd0;
               state_nxt = S_WB;
            end else begin
               cnt_nxt = cnt - 8'd1;
            end
         end
         S_WB: begin
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   assign mdu_busy  = !rst && (state != S_IDLE);
   assign mdu_wb_en = !rst && (state == S_WB);
   assign mdu_wb_rd = mdu_wb_en ? pend_rd : ZERO_RD;

   // ---------------------------------------------------------------------------
   // Stall generation
   // ---------------------------------------------------------------------------
   assign ld_haz = MemRead_IDEX && (rd_IDEX != ZERO_RD) &&
                   ((rd_IDEX == rs1_IFID) || (rd_IDEX == rs2_IFID));

   // Readers of pend_rd stay stalled through the WB cycle itself; the regfile
   // write lands at the end of WB, so the read in the following cycle is clean.
   assign sb_haz = (state != S_IDLE) &&
                   (is_mdu_IFID ||
                    ((pend_rd != ZERO_RD) &&
                     ((pend_rd == rs1_IFID) || (pend_rd == rs2_IFID))));

   assign stall       = !rst && (ld_haz || sb_haz);
   assign pc_hold     = stall;
   assign ifid_hold   = stall;
   assign idex_bubble = stall;

   // ---------------------------------------------------------------------------
   // Stall performance counter
   // ---------------------------------------------------------------------------
`ifdef HAZARD_PERF_CNT_EN
   localparam logic [CNT_W-1:0] CNT_ONE = 1;
   logic [CNT_W-1:0] stall_cnt;

   always_ff @(posedge clk) begin
      if (rst)
         stall_cnt <= '0;
      else if (stall && (stall_cnt != {CNT_W{1'b1}}))
         stall_cnt <= stall_cnt + CNT_ONE;
   end

   assign stall_cycles = rst ? {CNT_W{1'b0}} : stall_cnt;
`else
   assign stall_cycles = {CNT_W{1'b0}};
`endif

endmodule

// File: doc/hazard_ctrl_sb.md
Name: hazard_ctrl_sb

Overview:
- Combined forwarding, load-use stall and multi-cycle-unit scoreboard for the 5-stage RISC-V pipeline.
- Drives the operand forward selects for EX, and the PC/IF-ID hold and ID/EX bubble controls for the ID stage.
- Tracks one outstanding multi-cycle (MUL/DIV) operation with a latency counter and stalls dependent instructions until its writeback completes.

Parameters:
ADDR_W, 5, register-address width; register 0 is hardwired zero.
MDU_LAT, 4, cycles from MDU issue to the writeback cycle; legal range 1..255.
CNT_W, 32, width of the stall performance counter (only with the optional feature).

Ports:
clk  in  1  clock.
rst  in  1  reset, synchronous, active-high.
rs1_IFID, rs2_IFID  in  ADDR_W  sources of the instruction in ID.
is_mdu_IFID  in  1  the instruction in ID is a MUL/DIV.
rs1_IDEX, rs2_IDEX  in  ADDR_W  sources of the instruction in EX.
rd_IDEX  in  ADDR_W  destination of the instruction in EX.
MemRead_IDEX  in  1  the instruction in EX is a load.
rd_EXMEM  in  ADDR_W  destination of the instruction in MEM.
RegWrite_EXMEM  in  1  the instruction in MEM writes the register file.
rd_MEMWB  in  ADDR_W  destination of the instruction in WB.
RegWrite_MEMWB  in  1  the instruction in WB writes the register file.
mdu_start  in  1  1-cycle pulse: an MDU op issues from EX this cycle.
mdu_rd  in  ADDR_W  destination of the issuing MDU op.
ForwardA, ForwardB  out  2  00 = register file, 10 = EX/MEM result, 01 = MEM/WB result.
pc_hold  out  1  freeze the PC.
ifid_hold  out  1  freeze the IF/ID register.
idex_bubble  out  1  insert a NOP into ID/EX.
mdu_busy  out  1  a scoreboard entry is live (BUSY or WB state).
mdu_wb_en  out  1  MDU writeback strobe, for the register-file write port.
mdu_wb_rd  out  ADDR_W  MDU writeback destination.
stall_cycles  out  CNT_W  stall cycle counter.

Behaviour:
Forwarding (combinational):
- A path forwards when all hold: RegWrite_EXMEM=1, rd_EXMEM!=0, rd_EXMEM==rs1_IDEX. Then ForwardA=10.
- Otherwise, if RegWrite_MEMWB=1, rd_MEMWB!=0 and rd_MEMWB==rs1_IDEX, then ForwardA=01. Otherwise ForwardA=00.
- EX/MEM has priority over MEM/WB. The B path uses the same rules with rs2_IDEX.

Load-use hazard (combinational):
- ld_haz = MemRead_IDEX && rd_IDEX!=0 && (rd_IDEX==rs1_IFID || rd_IDEX==rs2_IFID).

Scoreboard FSM, states IDLE, BUSY, WB:
- Registered state: pend_rd, and cnt of width 8.
- IDLE: on mdu_start, latch pend_rd=mdu_rd and cnt=MDU_LAT-1. Go to WB if MDU_LAT==1, else go to BUSY.
- BUSY: decrement cnt each cycle. When cnt reaches 1, the next state is WB. Total BUSY duration is MDU_LAT-1 cycles.
- WB: lasts exactly 1 cycle; mdu_wb_en=1 and mdu_wb_rd=pend_rd. The next state is IDLE.
- mdu_start in BUSY or WB is ignored; no state change. This is a protocol violation, prevented by the structural stall below.
- mdu_start with mdu_rd==0 still runs the full sequence. mdu_wb_en is asserted and the register file discards the write.

MDU stall (combinational from registered state):
- sb_haz = (state!=IDLE) && (is_mdu_IFID || (pend_rd!=0 && (pend_rd==rs1_IFID || pend_rd==rs2_IFID))).
- Readers of pend_rd are stalled through the WB cycle and released the cycle after. No same-cycle write-through is relied on.

Stall outputs:
- pc_hold = ifid_hold = idex_bubble = ld_haz || sb_haz.
- Both hazards together produce a single stall, not an additive one.

Reset:
- rst=1 at a clock edge sets state=IDLE, pend_rd=0, cnt=0 and stall_cycles=0. This includes reset in the middle of an MDU op; the op is abandoned and no writeback occurs.
- While rst=1, all outputs are forced to 0, including ForwardA, ForwardB and the stall outputs.
- rst has priority over a simultaneous mdu_start.

Outputs after reset:
- mdu_busy=0, mdu_wb_en=0, mdu_wb_rd=0, stall_cycles=0.
- ForwardA/B and the stall outputs are combinational from the inputs.

Optional Feature:
HAZARD_PERF_CNT_EN:
- Defined: stall_cycles increments by 1 on every clock where pc_hold=1 and rst=0. It saturates at 2^CNT_W-1 and does not wrap.
- Undefined: no counter register exists and stall_cycles is tied to 0.

Test Plan:
1. Forward priority: rd_EXMEM=rd_MEMWB=rs1_IDEX=5, both RegWrite=1 -> ForwardA=10. Set RegWrite_EXMEM=0 -> ForwardA=01. Set rs1_IDEX=0 with rd_EXMEM=0 -> ForwardA=00.
2. Load-use: MemRead_IDEX=1, rd_IDEX=7, rs2_IFID=7 -> pc_hold/ifid_hold/idex_bubble=1 for that cycle. Set rd_IDEX=0 -> no stall.
3. MDU with MDU_LAT=4: mdu_start with mdu_rd=9 at cycle t. mdu_busy=1 for t+1..t+4. mdu_wb_en=1 with mdu_wb_rd=9 only at t+4. With rs1_IFID=9 held, the stall is asserted for t+1..t+4 and deasserted at t+5.
4. Structural: is_mdu_IFID=1 while BUSY -> stall until state returns to IDLE. A mdu_start pulse injected during BUSY leaves pend_rd and the WB cycle unchanged.
5. Reset mid-op: rst=1 two cycles after mdu_start -> the next cycle has mdu_busy=0, no mdu_wb_en pulse ever occurs, and stall_cycles=0. Also run with MDU_LAT=1: WB occurs in the cycle after start.
6. With HAZARD_PERF_CNT_EN and CNT_W=4: hold a load-use hazard for 20 cycles -> stall_cycles=15 (saturated). With the macro undefined -> stall_cycles=0 throughout.
